// File: rtl/ascon_perm_driver_if.sv
// ---------------------------------------------------------------------------
// ascon_perm_driver_if
// Bundles the host-side handshake and the core-side serial link of the
// Ascon permutation driver.
//   master : the driver itself (drives in_ready, out_valid, state_out,
//            perm_data, perm_load, start_permutation, constant,
//            perm_unload, err)
//   slave  : the environment (host producer/consumer plus the serial core)
// Host side : in_valid/in_ready/state_in, out_valid/out_ready/state_out
// Core side : perm_data, perm_load, start_permutation, const_req, constant,
//             perm_done, perm_state, perm_unload
// Status    : err (sticky protocol error)
// ---------------------------------------------------------------------------
interface ascon_perm_driver_if #(
  parameter int LANE_W = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [5*LANE_W-1:0]   state_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [5*LANE_W-1:0]   state_out;
  logic [4:0]            perm_data;
  logic                  perm_load;
  logic                  start_permutation;
  logic                  const_req;
  logic                  constant;
  logic                  perm_done;
  logic [4:0]            perm_state;
  logic                  perm_unload;
  logic                  err;

  modport master (
    input  in_valid, state_in, out_ready, const_req, perm_done, perm_state,
    output in_ready, out_valid, state_out, perm_data, perm_load,
           start_permutation, constant, perm_unload, err
  );

  modport slave (
    output in_valid, state_in, out_ready, const_req, perm_done, perm_state,
    input  in_ready, out_valid, state_out, perm_data, perm_load,
           start_permutation, constant, perm_unload, err
  );
endinterface

// File: rtl/ascon_perm_driver.sv
// ---------------------------------------------------------------------------
// ascon_perm_driver
// Host-side driver for a bit-serial Ascon round-permutation core. Takes a
// 5-lane state word, streams it to the core one column per cycle (MSB first),
// serves the round-constant bits the core asks for, then collects the
// permuted state column by column and offers it to the consumer.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active low
//   rounds_sel : (only with ASCON_DRV_VAR_ROUNDS_EN) per-job round count,
//                00=12, 01=8, 10=6, 11=12 with err raised
//   bus        : ascon_perm_driver_if.master, host handshake + core link
// Configuration macro: ASCON_DRV_VAR_ROUNDS_EN (default undefined, round
// count fixed by the ROUNDS parameter).
// ---------------------------------------------------------------------------
module ascon_perm_driver #(
  parameter int ROUNDS = 12,
  parameter int LANE_W = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef ASCON_DRV_VAR_ROUNDS_EN
  input  logic [1:0] rounds_sel,
`endif
  ascon_perm_driver_if.master bus
);

  localparam int CW = $clog2(LANE_W);
  localparam int SW = 5 * LANE_W;
  localparam logic [CW-1:0] CNT_LAST        = CW'(LANE_W - 1);
  // The 8-bit round constant occupies the last eight bit positions of a round.
  localparam logic [CW-1:0] CONST_FIRST_BIT = CW'(LANE_W - 8);
  localparam logic [3:0]    FIRST_IDX       = 4'(12 - ROUNDS);
  localparam logic [3:0]    LAST_ROUND      = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      round_r;
  logic [3:0]      first_idx_r;
  logic [3:0]      last_round_r;
  logic            spent_r;
  logic [SW-1:0]   shreg_r;
  logic            err_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            perm_load_r;
  logic            start_r;
  logic            perm_unload_r;

  logic            accept_s;
  logic            cnt_last_s;
  logic            serve_s;
  logic            last_bit_s;
  logic            all_spent_s;
  logic            bad_sel_s;
  logic            err_set_s;
  logic            constant_s;
  logic [3:0]      job_first_s;
  logic [3:0]      job_last_s;
  logic [3:0]      rc_idx_s;
  logic [7:0]      rc_byte_s;

  // Column made of the current MSB of every lane, x0 in bit 4.
  function automatic logic [4:0] top_column(input logic [SW-1:0] s);
    logic [4:0] col;
    col = 5'b00000;
    for (int l = 0; l < 5; l++) begin
      col[4-l] = s[SW-1-l*LANE_W];
    end
    return col;
  endfunction

  // Shift every lane left by one, inserting one column bit per lane at the LSB.
  function automatic logic [SW-1:0] shift_in_column(input logic [SW-1:0] s,
                                                    input logic [4:0]    col);
    logic [SW-1:0] res;
    res = {SW{1'b0}};
    for (int l = 0; l < 5; l++) begin
      res[SW-1-l*LANE_W -: LANE_W] = {s[SW-2-l*LANE_W -: LANE_W-1], col[4-l]};
    end
    return res;
  endfunction

  assign accept_s    = (state_r == ST_IDLE) && bus.in_valid;
  assign cnt_last_s  = (cnt_r == CNT_LAST);
  assign serve_s     = (state_r == ST_RUN) && bus.const_req && !spent_r;
  // The final bit of the final round is being consumed this cycle.
  assign last_bit_s  = serve_s && cnt_last_s && (round_r == last_round_r);
  assign all_spent_s = spent_r || last_bit_s;

  // Round-count selection for the job being accepted.
  always_comb begin
    job_first_s = FIRST_IDX;
    job_last_s  = LAST_ROUND;
    bad_sel_s   = 1'b0;
`ifdef ASCON_DRV_VAR_ROUNDS_EN
    case (rounds_sel)
      2'b00: begin
        job_first_s = 4'd0;
        job_last_s  = 4'd11;
      end
      2'b01: begin
        job_first_s = 4'd4;
        job_last_s  = 4'd7;
      end
      2'b10: begin
        job_first_s = 4'd6;
        job_last_s  = 4'd5;
      end
      default: begin
        job_first_s = 4'd0;
        job_last_s  = 4'd11;
        bad_sel_s   = 1'b1;
      end
    endcase
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_LOAD;
        else          state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (cnt_last_s) state_nxt_s = ST_START;
        else            state_nxt_s = ST_LOAD;
      end
      ST_START: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (bus.perm_done) state_nxt_s = ST_UNLOAD;
        else               state_nxt_s = ST_RUN;
      end
      ST_UNLOAD: begin
        if (cnt_last_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_UNLOAD;
      end
      ST_DONE: begin
        if (bus.out_ready) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: shared load/unload shift register and phase/bit/round counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r      <= {SW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      round_r      <= 4'd0;
      spent_r      <= 1'b0;
      first_idx_r  <= FIRST_IDX;
      last_round_r <= LAST_ROUND;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shreg_r      <= bus.state_in;
            cnt_r        <= {CW{1'b0}};
            round_r      <= 4'd0;
            spent_r      <= 1'b0;
            first_idx_r  <= job_first_s;
            last_round_r <= job_last_s;
          end else begin
            shreg_r <= shreg_r;
          end
        end
        ST_LOAD: begin
          // Lanes drain MSB first; by the end the register holds zeros and
          // is ready to receive the permuted columns.
          shreg_r <= shift_in_column(shreg_r, 5'b00000);
          if (cnt_last_s) cnt_r <= {CW{1'b0}};
          else            cnt_r <= cnt_r + CW'(1);
        end
        ST_START: begin
          cnt_r   <= {CW{1'b0}};
          round_r <= 4'd0;
          spent_r <= 1'b0;
        end
        ST_RUN: begin
          if (bus.perm_done) begin
            cnt_r <= {CW{1'b0}};
          end else if (serve_s) begin
            if (cnt_last_s) begin
              cnt_r <= {CW{1'b0}};
              if (round_r == last_round_r) spent_r <= 1'b1;
              else                         round_r <= round_r + 4'd1;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_UNLOAD: begin
          shreg_r <= shift_in_column(shreg_r, bus.perm_state);
          if (cnt_last_s) cnt_r <= {CW{1'b0}};
          else            cnt_r <= cnt_r + CW'(1);
        end
        ST_DONE: begin
          shreg_r <= shreg_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Round-constant bit: byte {0xF-i, i} served MSB first over the last 8 bits.
  always_comb begin
    rc_idx_s  = first_idx_r + round_r;
    rc_byte_s = {4'hF - rc_idx_s, rc_idx_s};
    if ((state_r == ST_RUN) && !spent_r && (cnt_r >= CONST_FIRST_BIT)) begin
      constant_s = rc_byte_s[~cnt_r[2:0]];
    end else begin
      constant_s = 1'b0;
    end
  end

  // Protocol-error detection.
  always_comb begin
    err_set_s = 1'b0;
    if (bus.const_req && ((state_r != ST_RUN) || spent_r)) begin
      err_set_s = 1'b1;
    end else if ((state_r == ST_RUN) && bus.perm_done && !all_spent_s) begin
      err_set_s = 1'b1;
    end else if (accept_s && bad_sel_s) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  // Phase flags registered from the next state so they align with the phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      perm_load_r   <= 1'b0;
      start_r       <= 1'b0;
      perm_unload_r <= 1'b0;
    end else begin
      in_ready_r    <= (state_nxt_s == ST_IDLE);
      out_valid_r   <= (state_nxt_s == ST_DONE);
      perm_load_r   <= (state_nxt_s == ST_LOAD);
      start_r       <= (state_nxt_s == ST_START);
      perm_unload_r <= (state_nxt_s == ST_UNLOAD);
    end
  end

  assign bus.in_ready          = in_ready_r;
  assign bus.out_valid         = out_valid_r;
  assign bus.state_out         = shreg_r;
  assign bus.perm_data         = perm_load_r ? top_column(shreg_r) : 5'b00000;
  assign bus.perm_load         = perm_load_r;
  assign bus.start_permutation = start_r;
  assign bus.constant          = constant_s;
  assign bus.perm_unload       = perm_unload_r;
  assign bus.err               = err_r;

endmodule

// File: tb/tb_ascon_perm_driver.sv
// ---------------------------------------------------------------------------
// tb_ascon_perm_driver
// Drives two driver instances (ROUNDS=12 and ROUNDS=6) with identical inputs
// and checks both against a round/bit arithmetic reference of the expected
// load columns, round constants, collected state and sticky error flag.
// ---------------------------------------------------------------------------
module tb_ascon_perm_driver;
  localparam int LW  = 64;
  localparam int SWD = 5 * LW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid;
  logic [SWD-1:0]  state_in;
  logic            out_ready;
  logic            const_req;
  logic            perm_done;
  logic [4:0]      perm_state;

  int   checks   = 0;
  int   failures = 0;
  logic err12_exp;
  logic err6_exp;

  ascon_perm_driver_if #(.LANE_W(LW)) bus12();
  ascon_perm_driver_if #(.LANE_W(LW)) bus6();

  assign bus12.in_valid   = in_valid;
  assign bus12.state_in   = state_in;
  assign bus12.out_ready  = out_ready;
  assign bus12.const_req  = const_req;
  assign bus12.perm_done  = perm_done;
  assign bus12.perm_state = perm_state;
  assign bus6.in_valid    = in_valid;
  assign bus6.state_in    = state_in;
  assign bus6.out_ready   = out_ready;
  assign bus6.const_req   = const_req;
  assign bus6.perm_done   = perm_done;
  assign bus6.perm_state  = perm_state;

  ascon_perm_driver #(.ROUNDS(12), .LANE_W(LW)) dut12 (
    .clk (clk),
    .rst (rst),
`ifdef ASCON_DRV_VAR_ROUNDS_EN
    .rounds_sel (2'b00),
`endif
    .bus (bus12)
  );

  ascon_perm_driver #(.ROUNDS(6), .LANE_W(LW)) dut6 (
    .clk (clk),
    .rst (rst),
`ifdef ASCON_DRV_VAR_ROUNDS_EN
    .rounds_sel (2'b10),
`endif
    .bus (bus6)
  );

  task automatic check_eq(input string tag, input logic [SWD-1:0] obs,
                          input logic [SWD-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected constant bit after k bits consumed in a permutation of 'rounds'.
  function automatic logic exp_const(input int rounds, input int k);
    int r;
    int b;
    int i;
    logic [7:0] c;
    if (k >= rounds * 64) return 1'b0;
    r = k / 64;
    b = k % 64;
    i = 12 - rounds + r;
    c = 8'(((15 - i) * 16) + i);
    if (b < 56) return 1'b0;
    return c[63 - b];
  endfunction

  function automatic logic [SWD-1:0] rand_state();
    logic [SWD-1:0] v;
    for (int w = 0; w < 10; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready12"},  SWD'(bus12.in_ready),  SWD'(1'b1));
    check_eq({tag, "_in_ready6"},   SWD'(bus6.in_ready),   SWD'(1'b1));
    check_eq({tag, "_out_valid12"}, SWD'(bus12.out_valid), SWD'(1'b0));
    check_eq({tag, "_perm_load12"}, SWD'(bus12.perm_load), SWD'(1'b0));
    check_eq({tag, "_perm_load6"},  SWD'(bus6.perm_load),  SWD'(1'b0));
    check_eq({tag, "_err12"},       SWD'(bus12.err),       SWD'(1'b0));
    check_eq({tag, "_err6"},        SWD'(bus6.err),        SWD'(1'b0));
    check_eq({tag, "_state_out12"}, bus12.state_out,       {SWD{1'b0}});
    check_eq({tag, "_start12"},     SWD'(bus12.start_permutation), SWD'(1'b0));
    check_eq({tag, "_constant12"},  SWD'(bus12.constant),  SWD'(1'b0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    err12_exp = 1'b0;
    err6_exp  = 1'b0;
    @(negedge clk);
  endtask

  // One complete job: load, run with nreq constant requests, unload, handshake.
  task automatic run_job(input logic [SWD-1:0] s, input int nreq, input bit coincide,
                         input bit alt_cols, input int stall);
    logic [4:0]     cols [64];
    logic [4:0]     exp_col;
    logic [SWD-1:0] exp_out;
    int   waited;
    int   k;
    bit   req;
    bit   done_sent;

    waited = 0;
    while (bus12.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("idle_ready", SWD'(bus12.in_ready), SWD'(1'b1));

    in_valid = 1'b1;
    state_in = s;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("busy_not_ready", SWD'(bus12.in_ready), SWD'(1'b0));

    for (int c = 0; c < 64; c++) begin
      for (int l = 0; l < 5; l++) exp_col[4-l] = s[SWD-1-l*LW-c];
      check_eq("perm_load12", SWD'(bus12.perm_load), SWD'(1'b1));
      check_eq("perm_data12", SWD'(bus12.perm_data), SWD'(exp_col));
      check_eq("perm_data6",  SWD'(bus6.perm_data),  SWD'(exp_col));
      // Stray in_valid / perm_done during LOAD must change nothing.
      in_valid  = ($urandom_range(0, 3) == 0);
      state_in  = rand_state();
      perm_done = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    perm_done = 1'b0;

    check_eq("start12",      SWD'(bus12.start_permutation), SWD'(1'b1));
    check_eq("start6",       SWD'(bus6.start_permutation),  SWD'(1'b1));
    check_eq("load_off",     SWD'(bus12.perm_load),         SWD'(1'b0));
    @(negedge clk);

    k = 0;
    done_sent = 1'b0;
    for (int cyc = 0; cyc < 4 * nreq + 20 && !done_sent; cyc++) begin
      if (cyc == 0) check_eq("start_pulse_once", SWD'(bus12.start_permutation), SWD'(1'b0));
      check_eq("const12", SWD'(bus12.constant), SWD'(exp_const(12, k)));
      check_eq("const6",  SWD'(bus6.constant),  SWD'(exp_const(6, k)));
      req = (k < nreq) && ($urandom_range(0, 2) != 0);
      if (req && coincide && (k == nreq - 1)) begin
        perm_done = 1'b1;
      end else if (k >= nreq) begin
        perm_done = 1'b1;
      end else begin
        perm_done = 1'b0;
      end
      const_req = req;
      if (req) k++;
      done_sent = perm_done;
      @(negedge clk);
      const_req = 1'b0;
      perm_done = 1'b0;
    end
    check_eq("run_budget", SWD'(done_sent), SWD'(1'b1));

    if (nreq != 12 * 64) err12_exp = 1'b1;
    if (nreq != 6 * 64)  err6_exp  = 1'b1;

    for (int c = 0; c < 64; c++) begin
      check_eq("perm_unload12", SWD'(bus12.perm_unload), SWD'(1'b1));
      check_eq("perm_unload6",  SWD'(bus6.perm_unload),  SWD'(1'b1));
      if (c == 0) check_eq("const_off_run", SWD'(bus12.constant), SWD'(1'b0));
      if (alt_cols) cols[c] = (c % 2 == 0) ? 5'b11111 : 5'b00000;
      else          cols[c] = 5'($urandom_range(0, 31));
      perm_state = cols[c];
      @(negedge clk);
    end
    perm_state = 5'b00000;

    exp_out = {SWD{1'b0}};
    for (int c = 0; c < 64; c++) begin
      for (int l = 0; l < 5; l++) exp_out[SWD-1-l*LW-c] = cols[c][4-l];
    end

    out_ready = 1'b0;
    for (int t = 0; t <= stall; t++) begin
      check_eq("out_valid12", SWD'(bus12.out_valid), SWD'(1'b1));
      check_eq("out_valid6",  SWD'(bus6.out_valid),  SWD'(1'b1));
      check_eq("state_out12", bus12.state_out, exp_out);
      check_eq("state_out6",  bus6.state_out,  exp_out);
      if (t == stall) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check_eq("out_valid_drop", SWD'(bus12.out_valid), SWD'(1'b0));
    check_eq("ready_again12",  SWD'(bus12.in_ready),  SWD'(1'b1));
    check_eq("ready_again6",   SWD'(bus6.in_ready),   SWD'(1'b1));
    check_eq("err12", SWD'(bus12.err), SWD'(err12_exp));
    check_eq("err6",  SWD'(bus6.err),  SWD'(err6_exp));
  endtask

  initial begin
    int nreq;
    rst        = 1'b0;
    in_valid   = 1'b0;
    state_in   = {SWD{1'b0}};
    out_ready  = 1'b0;
    const_req  = 1'b0;
    perm_done  = 1'b0;
    perm_state = 5'b00000;
    err12_exp  = 1'b0;
    err6_exp   = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    // Single set bit in x0 MSB, alternating returned columns, 10-cycle stall.
    run_job({64'h8000_0000_0000_0000, 256'd0}, 384, 1'b0, 1'b1, 10);

    do_reset();
    run_job(rand_state(), 768, 1'b1, 1'b0, 3);

    // const_req while idle raises err; reset mid-LOAD clears everything.
    const_req = 1'b1;
    @(negedge clk);
    const_req = 1'b0;
    err12_exp = 1'b1;
    err6_exp  = 1'b1;
    check_eq("err_idle_req12", SWD'(bus12.err), SWD'(err12_exp));
    check_eq("err_idle_req6",  SWD'(bus6.err),  SWD'(err6_exp));
    state_in = rand_state();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("mid_load_active", SWD'(bus12.perm_load), SWD'(1'b1));
    rst = 1'b0;
    @(negedge clk);
    err12_exp = 1'b0;
    err6_exp  = 1'b0;
    check_reset_vals("midload");
    rst = 1'b1;
    @(negedge clk);

    // Premature perm_done after 100 constant bits.
    run_job(rand_state(), 100, 1'b0, 1'b0, 0);

    for (int j = 0; j < 8; j++) begin
      if (j == 4) do_reset();
      case ($urandom_range(0, 4))
        0:       nreq = 384;
        1:       nreq = 768;
        2:       nreq = int'($urandom_range(1, 383));
        3:       nreq = int'($urandom_range(385, 767));
        default: nreq = 768 + int'($urandom_range(1, 20));
      endcase
      run_job(rand_state(), nreq, 1'($urandom_range(0, 1)), 1'b0,
              int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
